// File: rtl/pci_initiator.sv
// rtl/pci_initiator.sv - PCI bus initiator with a 4-entry burst buffer
// Runs one read or write burst of 1..4 beats and reports done or master/target abort.
module pci_initiator #(
  parameter int ABORT_CYCLES = 5
) (
  input  logic        clk,
  input  logic        RST,
  input  logic        req,
  input  logic [3:0]  cmd,
  input  logic [31:0] addr,
  input  logic [1:0]  len,
  input  logic        buf_we,
  input  logic [1:0]  buf_idx,
  input  logic [31:0] buf_wdata,
  input  logic [3:0]  buf_wbe,
  output logic [31:0] buf_rdata,
  output logic        busy,
  output logic        done,
  output logic        abort,
  output logic        Frame,
  output logic        IRDY,
  output logic [3:0]  CBE,
  inout  wire  [31:0] AD,
  input  logic        DEVSEL,
  input  logic        TRDY
);
  localparam logic [3:0] CMD_READ  = 4'b0010;
  localparam logic [3:0] CMD_WRITE = 4'b0011;
  localparam int CW = (ABORT_CYCLES < 2) ? 1 : $clog2(ABORT_CYCLES + 1);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_DONE, S_ABORT} state_t;

  state_t        state_q, state_d;
  logic [3:0]    cmd_q, cmd_d;
  logic [31:0]   addr_q, addr_d;
  logic [1:0]    len_q, len_d;
  logic [1:0]    beat_q, beat_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          seen_q, seen_d;
  logic [31:0]   data_q [4];
  logic [31:0]   data_d [4];
  logic [3:0]    be_q [4];
  logic [3:0]    be_d [4];

  logic [CW:0]   cnt_nxt;
  logic          cnt_expired;
  logic          ad_oe, cbe_oe;
  logic [31:0]   ad_val;
  logic [3:0]    cbe_val;

  // The ADDR edge counts as the first DEVSEL sample of the abort window.
  assign cnt_nxt     = {1'b0, cnt_q} + (CW+1)'(1);
  assign cnt_expired = cnt_nxt >= (CW+1)'(ABORT_CYCLES);

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    addr_d  = addr_q;
    len_d   = len_q;
    beat_d  = beat_q;
    cnt_d   = cnt_q;
    seen_d  = seen_q;
    data_d  = data_q;
    be_d    = be_q;
    if (buf_we && state_q == S_IDLE) begin
      data_d[buf_idx] = buf_wdata;
      be_d[buf_idx]   = buf_wbe;
    end
    case (state_q)
      S_IDLE: begin
        if (req && (cmd == CMD_READ || cmd == CMD_WRITE)) begin
          cmd_d   = cmd;
          addr_d  = addr;
          len_d   = len;
          beat_d  = 2'd0;
          cnt_d   = '0;
          seen_d  = 1'b0;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        state_d = S_DATA;
        if (!DEVSEL) seen_d = 1'b1;
        else if (cnt_expired) state_d = S_ABORT;
        else cnt_d = cnt_nxt[CW-1:0];
      end
      S_DATA: begin
        if (DEVSEL) begin
          if (seen_q || cnt_expired) state_d = S_ABORT;
          else cnt_d = cnt_nxt[CW-1:0];
        end else begin
          seen_d = 1'b1;
          if (!TRDY) begin
            if (cmd_q == CMD_READ) data_d[beat_q] = AD;
            beat_d = beat_q + 2'd1;
            if (beat_q == len_q) state_d = S_DONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state_q <= S_IDLE;
      cmd_q   <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      cnt_q   <= '0;
      seen_q  <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        data_q[i] <= '0;
        be_q[i]   <= '0;
      end
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      cnt_q   <= cnt_d;
      seen_q  <= seen_d;
      data_q  <= data_d;
      be_q    <= be_d;
    end
  end

  always_comb begin
    busy    = state_q != S_IDLE;
    done    = state_q == S_DONE;
    abort   = state_q == S_ABORT;
    Frame   = !(state_q == S_ADDR || (state_q == S_DATA && beat_q != len_q));
    IRDY    = state_q != S_DATA;
    cbe_oe  = state_q == S_ADDR || state_q == S_DATA;
    cbe_val = (state_q == S_ADDR) ? cmd_q : be_q[beat_q];
    ad_oe   = state_q == S_ADDR || (state_q == S_DATA && cmd_q == CMD_WRITE);
    ad_val  = (state_q == S_ADDR) ? addr_q : data_q[beat_q];
  end

  assign AD        = ad_oe ? ad_val : 32'bz;
  assign CBE       = cbe_oe ? cbe_val : 4'bz;
  assign buf_rdata = data_q[buf_idx];
endmodule

// File: tb/tb_pci_initiator.sv
// tb/tb_pci_initiator.sv - scoreboard bench for pci_initiator
// Drives host requests and a behavioural PCI target with 4 words at 0x10.
module tb_pci_initiator;
  localparam logic [3:0] C_READ  = 4'b0010;
  localparam logic [3:0] C_WRITE = 4'b0011;

  logic clk = 1'b0;
  logic RST = 1'b1;
  logic req = 1'b0;
  logic [3:0] cmd = '0;
  logic [31:0] addr = '0;
  logic [1:0] len = '0;
  logic buf_we = 1'b0;
  logic [1:0] buf_idx = '0;
  logic [31:0] buf_wdata = '0;
  logic [3:0] buf_wbe = '0;
  logic DEVSEL = 1'b1;
  logic TRDY = 1'b1;
  logic tgt_oe = 1'b0;
  logic [31:0] tgt_data = '0;
  wire [31:0] buf_rdata;
  wire busy, done, abort, Frame, IRDY;
  wire [3:0] CBE;
  wire [31:0] AD;

  assign AD = tgt_oe ? tgt_data : 32'bz;

  pci_initiator #(.ABORT_CYCLES(5)) dut (
    .clk(clk), .RST(RST), .req(req), .cmd(cmd), .addr(addr), .len(len),
    .buf_we(buf_we), .buf_idx(buf_idx), .buf_wdata(buf_wdata), .buf_wbe(buf_wbe),
    .buf_rdata(buf_rdata), .busy(busy), .done(done), .abort(abort),
    .Frame(Frame), .IRDY(IRDY), .CBE(CBE), .AD(AD), .DEVSEL(DEVSEL), .TRDY(TRDY)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0, chk_cnt = 0;
  int cyc = 0, done_cnt = 0, abort_cnt = 0, both_cnt = 0, frame_low = 0, irdy_low = 0;
  int addr_cyc = 0, abort_cyc = 0, addr_seen = 0, rd_drive = 0;
  logic [31:0] mem [4];
  logic [31:0] sh_d [4];
  logic [3:0]  sh_be [4];
  logic [35:0] wr_q [$];
  logic [31:0] rd_q [$];
  logic t_active = 1'b0, t_read = 1'b0;
  int t_beat = 0, t_wait = 0, wait_cfg = 0;

  task automatic check_eq(input string tag, input logic [35:0] got, input logic [35:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic ad_free();
    return $isunknown(AD) || (AD == 32'h0);
  endfunction

  function automatic logic cbe_free();
    return $isunknown(CBE) || (CBE == 4'h0);
  endfunction

  // Target decides DEVSEL/TRDY/AD for the coming edge from the outputs of this cycle.
  task automatic target_step();
    logic [35:0] e;
    tgt_oe = 1'b0;
    DEVSEL = 1'b1;
    TRDY   = 1'b1;
    #1;
    if (!Frame && IRDY) begin
      addr_cyc = cyc;
      addr_seen++;
      t_active = (AD[31:4] == 28'h1);
      t_read   = (CBE == C_READ);
      t_beat   = 0;
      t_wait   = wait_cfg;
    end else if (!IRDY && t_active) begin
      if (t_read && !ad_free()) rd_drive++;
      DEVSEL = 1'b0;
      if (t_read) begin
        tgt_oe   = 1'b1;
        tgt_data = mem[t_beat[1:0]];
      end
      if (t_wait > 0) begin
        t_wait--;
        if (!t_read && wr_q.size() > 0) check_eq("wait_hold", {CBE, AD}, wr_q[0]);
      end else begin
        TRDY = 1'b0;
        if (!t_read) begin
          if (wr_q.size() == 0) check_eq("wr_extra_beat", 36'(1), 36'(0));
          else begin
            e = wr_q.pop_front();
            check_eq("wr_beat", {CBE, AD}, e);
          end
          for (int b = 0; b < 4; b++)
            if (CBE[b]) mem[t_beat[1:0]][8*b +: 8] = AD[8*b +: 8];
        end
        t_beat++;
        if (Frame) t_active = 1'b0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (done) done_cnt++;
    if (abort) begin
      abort_cnt++;
      abort_cyc = cyc;
    end
    if (done && abort) both_cnt++;
    if (!Frame) frame_low++;
    if (!IRDY) irdy_low++;
    target_step();
  endtask

  task automatic clear_counts();
    done_cnt = 0; abort_cnt = 0; frame_low = 0; irdy_low = 0; addr_seen = 0; rd_drive = 0;
  endtask

  task automatic load(input logic [1:0] i, input logic [31:0] d, input logic [3:0] be);
    buf_we = 1'b1; buf_idx = i; buf_wdata = d; buf_wbe = be;
    if (!busy) begin
      sh_d[i] = d;
      sh_be[i] = be;
    end
    tick();
    buf_we = 1'b0;
  endtask

  task automatic start(input logic [3:0] c, input logic [31:0] a, input logic [1:0] l);
    for (int i = 0; i <= int'(l); i++) begin
      if (c == C_WRITE) wr_q.push_back({sh_be[i], sh_d[i]});
      else rd_q.push_back(mem[i]);
    end
    req = 1'b1; cmd = c; addr = a; len = l;
    tick();
    req = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 60) begin
      tick();
      n++;
    end
    check_eq(tag, 36'(busy), 36'(0));
  endtask

  task automatic read_buf(input logic [1:0] i, output logic [31:0] v);
    buf_idx = i;
    #1;
    v = buf_rdata;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  initial begin
    logic [31:0] v;
    for (int i = 0; i < 4; i++) begin
      mem[i] = '0; sh_d[i] = '0; sh_be[i] = '0;
    end

    tick(); tick();
    RST = 1'b0;
    check_eq("rst_frame", 36'(Frame), 36'(1));
    check_eq("rst_irdy", 36'(IRDY), 36'(1));
    check_eq("rst_busy", 36'(busy), 36'(0));
    check_eq("rst_done_abort", 36'({done, abort}), 36'(0));
    check_eq("rst_ad_z", 36'(ad_free()), 36'(1));
    check_eq("rst_cbe_z", 36'(cbe_free()), 36'(1));
    for (int i = 0; i < 4; i++) begin
      read_buf(i[1:0], v);
      check_eq("rst_buf", 36'(v), 36'(0));
    end

    // Write burst of four beats with alternating byte enables.
    load(2'd0, 32'h1001, 4'b0000);
    load(2'd1, 32'h1002, 4'b1111);
    load(2'd2, 32'h1003, 4'b0000);
    load(2'd3, 32'h1004, 4'b1111);
    clear_counts();
    start(C_WRITE, 32'h10, 2'd3);
    wait_idle("wr_end");
    check_eq("wr_frame_low", 36'(frame_low), 36'(4));
    check_eq("wr_irdy_low", 36'(irdy_low), 36'(4));
    check_eq("wr_done", 36'(done_cnt), 36'(1));
    check_eq("wr_no_abort", 36'(abort_cnt), 36'(0));
    check_eq("wr_left", 36'(wr_q.size()), 36'(0));
    check_eq("mem0", 36'(mem[0]), 36'(32'h0));
    check_eq("mem1", 36'(mem[1]), 36'(32'h1002));
    check_eq("mem2", 36'(mem[2]), 36'(32'h0));
    check_eq("mem3", 36'(mem[3]), 36'(32'h1004));
    check_eq("idle_ad_z", 36'(ad_free()), 36'(1));

    // Read burst of two beats with one wait state on the first beat.
    for (int i = 0; i < 4; i++) mem[i] = 32'hCAFE0001 + i;
    wait_cfg = 1;
    clear_counts();
    start(C_READ, 32'h10, 2'd1);
    wait_idle("rd_end");
    check_eq("rd_irdy_low", 36'(irdy_low), 36'(3));
    check_eq("rd_done", 36'(done_cnt), 36'(1));
    check_eq("rd_ad_released", 36'(rd_drive), 36'(0));
    for (int i = 0; i < 2; i++) begin
      read_buf(i[1:0], v);
      if (rd_q.size() == 0) check_eq("rd_missing", 36'(1), 36'(0));
      else begin
        sh_d[i] = rd_q.pop_front();
        check_eq("rd_buf", 36'(v), 36'(sh_d[i]));
      end
    end
    read_buf(2'd2, v);
    check_eq("rd_buf2_kept", 36'(v), 36'(sh_d[2]));
    read_buf(2'd3, v);
    check_eq("rd_buf3_kept", 36'(v), 36'(sh_d[3]));

    // Master abort: nothing answers at 0x20.
    wait_cfg = 0;
    clear_counts();
    start(C_WRITE, 32'h20, 2'd3);
    wait_idle("ab_end");
    check_eq("ab_latency", 36'(abort_cyc - addr_cyc), 36'(5));
    check_eq("ab_pulse", 36'(abort_cnt), 36'(1));
    check_eq("ab_no_done", 36'(done_cnt), 36'(0));
    check_eq("ab_after_frame_irdy", 36'({Frame, IRDY}), 36'(2'b11));
    check_eq("ab_no_beats", 36'(wr_q.size()), 36'(4));
    wr_q.delete();

    // req and buf_we while busy must be ignored.
    wait_cfg = 1;
    clear_counts();
    start(C_WRITE, 32'h10, 2'd3);
    tick();
    req = 1'b1; cmd = C_READ; addr = 32'h10; len = 2'd0;
    buf_we = 1'b1; buf_idx = 2'd0; buf_wdata = 32'hDEADBEEF; buf_wbe = 4'hF;
    tick(); tick();
    req = 1'b0; buf_we = 1'b0;
    wait_idle("busy_end");
    tick(); tick(); tick();
    check_eq("busy_done", 36'(done_cnt), 36'(1));
    check_eq("busy_one_txn", 36'(addr_seen), 36'(1));
    check_eq("busy_left", 36'(wr_q.size()), 36'(0));
    read_buf(2'd0, v);
    check_eq("busy_buf0", 36'(v), 36'(sh_d[0]));

    // Reset sampled on the edge that would complete beat 2.
    wait_cfg = 0;
    clear_counts();
    start(C_WRITE, 32'h10, 2'd3);
    for (int n = 0; n < 20 && t_beat != 3; n++) tick();
    check_eq("mid_reached", 36'(t_beat), 36'(3));
    RST = 1'b1;
    tick();
    RST = 1'b0;
    t_active = 1'b0;
    check_eq("mid_frame_irdy", 36'({Frame, IRDY}), 36'(2'b11));
    check_eq("mid_ad_z", 36'(ad_free()), 36'(1));
    check_eq("mid_cbe_z", 36'(cbe_free()), 36'(1));
    check_eq("mid_busy", 36'(busy), 36'(0));
    for (int i = 0; i < 4; i++) begin
      read_buf(i[1:0], v);
      check_eq("mid_buf", 36'(v), 36'(0));
    end
    check_eq("mid_left", 36'(wr_q.size()), 36'(1));
    wr_q.delete();
    tick(); tick();
    check_eq("mid_no_pulse", 36'(done_cnt + abort_cnt), 36'(0));
    check_eq("never_both", 36'(both_cnt), 36'(0));

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/pci_initiator.md
PCI_INITIATOR -- requirements
Module: pci_initiator

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning): ABORT_CYCLES, 5, number of sampled clocks without DEVSEL low before a master abort.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
  clk  in  1  sole clock; all state updates on rising edge
  RST  in  1  synchronous reset, active-high
  req  in  1  host start request
  cmd  in  4  PCI command; 4'b0010 read, 4'b0011 write
  addr  in  32  target address
  len  in  2  burst length minus 1 (1..4 beats)
  buf_we  in  1  host write-buffer load strobe
  buf_idx  in  2  buffer entry select, for load and readback
  buf_wdata  in  32  data loaded into buffer entry
  buf_wbe  in  4  byte-enable (CBE) loaded with the entry
  buf_rdata  out  32  combinational readout of buffer[buf_idx]
  busy  out  1  transaction in progress
  done  out  1  one-cycle pulse on normal completion
  abort  out  1  one-cycle pulse on master abort
  Frame  out  1  PCI FRAME#, active-low
  IRDY  out  1  PCI IRDY#, active-low
  CBE  out  4  command in the address phase, byte enables in data phases
  AD  inout  32  multiplexed address/data
  DEVSEL  in  1  PCI DEVSEL#, active-low, from target
  TRDY  in  1  PCI TRDY#, active-low, from target
REQ-003 Clocking and reset SHALL be: one clock (clk); synchronous, active-high reset (RST).

Function
REQ-004 The buffer SHALL have 4 entries of {32-bit data, 4-bit BE}; buf_we loads an entry only when busy=0.
REQ-005 States SHALL be IDLE, ADDR, DATA, DONE, ABORT.
REQ-006 IDLE SHALL drive: Frame=1, IRDY=1, CBE=Z, AD=Z, busy=0.
REQ-007 In IDLE, req=1 with cmd in {0010, 0011} SHALL latch cmd/addr/len, clear beat counter, and move to ADDR; other cmd values are ignored.
REQ-008 req SHALL be ignored while busy=1.
REQ-009 ADDR SHALL last exactly one cycle: Frame=0, IRDY=1, AD=addr, CBE=cmd, busy=1; then DATA.
REQ-010 In DATA, IRDY SHALL be 0 and CBE SHALL be buffer[beat].BE.
REQ-011 In DATA for writes, AD SHALL be buffer[beat].data; for reads, AD SHALL be Z for the whole data phase (turnaround included).
REQ-012 Frame SHALL be 1 in any DATA cycle where beat==len (last beat), otherwise 0.
REQ-013 A beat SHALL complete on a rising edge sampling IRDY=0, TRDY=0, DEVSEL=0; wait states (TRDY=1) hold beat, AD, and CBE unchanged.
REQ-014 On read beat completion, buffer[beat].data SHALL be AD sampled at that edge.
REQ-015 Beat counter SHALL be 2-bit and increment per completed beat; completing beat==len SHALL move to DONE.
REQ-016 DONE SHALL last one cycle: done=1, Frame=1, IRDY=1, AD/CBE=Z; then IDLE.
REQ-017 Master abort: DEVSEL never sampled 0 within ABORT_CYCLES edges after ADDR SHALL move to ABORT.
REQ-018 Target drop: DEVSEL sampled 1 after having been 0, before the last beat completes, SHALL move to ABORT.
REQ-019 ABORT SHALL last one cycle: abort=1, Frame=1, IRDY=1, AD/CBE=Z; then IDLE; buffer entries already received are kept.
REQ-020 done and abort SHALL never be 1 in the same cycle.
REQ-021 AD SHALL be driven only in ADDR and write DATA cycles, never in IDLE/DONE/ABORT.

Reset
REQ-022 RST=1 at a rising edge SHALL force IDLE from any state, including mid-burst, with no done/abort pulse.
REQ-023 Reset values SHALL be: Frame=1, IRDY=1, CBE=Z, AD=Z, busy=0, done=0, abort=0, beat=0, all buffer entries 0.
REQ-024 The abort timeout counter SHALL be cleared by reset.

Verification
REQ-025 Write burst: load {1001,0000},{1002,1111},{1003,0000},{1004,1111}; req with cmd=0011, addr=0x10, len=3; target at 0x10 zero-wait -> Frame low 4 cycles, IRDY low 4 cycles, 4 beats; target memory ends {0,1002,0,1004}; done pulses once.
REQ-026 Read burst: cmd=0010, addr=0x10, len=1; TRDY held 1 for one cycle -> AD Z throughout data phase; buffer[0..1]=target words; IRDY low 3 cycles; done once.
REQ-027 Master abort: addr=0x20 (no target) -> DEVSEL stays 1; abort pulses 5 cycles after ADDR; Frame=1/IRDY=1 next; no done.
REQ-028 Reset mid-burst: RST during beat 2 of a 4-beat write -> next edge Frame=1, IRDY=1, AD=Z, busy=0, buffer all 0, no done/abort.
REQ-029 Busy rules: req and buf_we during a write -> ignored; buffer contents and transfer unchanged.
